// File: rtl/ei_axi4_slave_mem_if.sv
// AXI4 bus bundle for the word-addressed slave memory (full 32-bit beats, no size/lock/cache).
interface ei_axi4_slave_mem_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave backed by a word memory; independent single-outstanding write and read engines
// supporting FIXED/INCR/WRAP bursts with SLVERR/DECERR reporting.
module ei_axi4_slave_mem #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input logic                aclk,
    input logic                aresetn,
    ei_axi4_slave_mem_if.slave axi
);
    localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] MemBytes = (ADDR_WIDTH + 1)'(MEM_DEPTH) << 2;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // Illegal WRAP lengths and the reserved encoding fall back to INCR.
    function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
        if (burst == 2'b11) return BurstIncr;
        if (burst == BurstWrap && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return BurstIncr;
        return burst;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] inc;
        mask = ADDR_WIDTH'({len, 2'b11});
        inc  = a + ADDR_WIDTH'(4);
        case (burst)
            BurstFixed: return a;
            BurstWrap:  return (a & ~mask) | (inc & mask);
            default:    return inc;
        endcase
    endfunction

    function automatic logic oor(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} >= MemBytes;
    endfunction

    function automatic logic [IdxW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IdxW+1:2];
    endfunction

    logic [31:0] mem_q [MEM_DEPTH];

    logic                  live_q;
    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]            w_burst_q, w_burst_d, bresp_q, bresp_d, w_beat_resp;
    logic                  mem_we, aw_ready;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, ld_addr;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d, ld_cnt;
    logic [1:0]            r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic                  r_err_q, r_err_d, rlast_q, rlast_d, ld, ar_ready;
    logic [31:0]           rdata_q, rdata_d;

    // Ready is held low until the first edge after reset release.
    assign aw_ready    = live_q && (w_state_q == WIdle);
    assign ar_ready    = live_q && (r_state_q == RIdle);
    assign axi.awready = aw_ready;
    assign axi.wready  = (w_state_q == WData);
    assign axi.bvalid  = (w_state_q == WResp);
    assign axi.bid     = w_id_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = ar_ready;
    assign axi.rvalid  = (r_state_q == RData);
    assign axi.rid     = r_id_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;

    always_comb begin
        w_state_d   = w_state_q;
        w_id_d      = w_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_burst_d   = w_burst_q;
        bresp_d     = bresp_q;
        w_beat_resp = RespOkay;
        mem_we      = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                if (axi.awvalid && aw_ready) begin
                    w_id_d    = axi.awid;
                    w_addr_d  = axi.awaddr & ~ADDR_WIDTH'(3);
                    w_len_d   = axi.awlen;
                    w_burst_d = eff_burst(axi.awburst, axi.awlen);
                    bresp_d   = (w_burst_d != axi.awburst) ? RespSlverr : RespOkay;
                    w_cnt_d   = '0;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (axi.wvalid) begin
                    mem_we = !oor(w_addr_q);
                    if (oor(w_addr_q)) begin
                        w_beat_resp = RespDecerr;
                    end else if (axi.wlast != (w_cnt_q == w_len_q)) begin
                        w_beat_resp = RespSlverr;
                    end
                    // Encodings order by severity, so the numeric max is the worst response.
                    if (w_beat_resp > bresp_q) bresp_d = w_beat_resp;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = WResp;
                    end else begin
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_addr_d = step_addr(w_addr_q, w_len_q, w_burst_q);
                    end
                end
            end
            WResp: begin
                if (axi.bready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        ld        = 1'b0;
        ld_addr   = r_addr_q;
        ld_cnt    = r_cnt_q;
        unique case (r_state_q)
            RIdle: begin
                if (axi.arvalid && ar_ready) begin
                    r_id_d    = axi.arid;
                    r_len_d   = axi.arlen;
                    r_burst_d = eff_burst(axi.arburst, axi.arlen);
                    r_err_d   = (r_burst_d != axi.arburst);
                    ld        = 1'b1;
                    ld_addr   = axi.araddr & ~ADDR_WIDTH'(3);
                    ld_cnt    = '0;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (axi.rready) begin
                    if (rlast_q) begin
                        r_state_d = RIdle;
                    end else begin
                        ld      = 1'b1;
                        ld_addr = step_addr(r_addr_q, r_len_q, r_burst_q);
                        ld_cnt  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
        // Array read happens before the same-edge write lands, so reads see old data.
        if (ld) begin
            r_addr_d = ld_addr;
            r_cnt_d  = ld_cnt;
            rlast_d  = (ld_cnt == r_len_d);
            if (oor(ld_addr)) begin
                rdata_d = '0;
                rresp_d = RespDecerr;
            end else begin
                rdata_d = mem_q[idx(ld_addr)];
                rresp_d = r_err_d ? RespSlverr : RespOkay;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_q    <= 1'b0;
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            bresp_q   <= '0;
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // Contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (axi.wstrb[i]) mem_q[idx(w_addr_q)][8*i +: 8] <= axi.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Self-checking bench for ei_axi4_slave_mem: directed scenarios plus randomized bursts against
// a flat-array memory model.
module tb_ei_axi4_slave_mem;
    localparam int unsigned IdW      = 4;
    localparam int unsigned AddrW    = 32;
    localparam int unsigned Depth    = 1024;
    localparam int unsigned MemBytes = Depth * 4;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] ref_mem [Depth];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    ei_axi4_slave_mem_if #(.ID_WIDTH(IdW), .ADDR_WIDTH(AddrW)) axi ();

    ei_axi4_slave_mem #(.ID_WIDTH(IdW), .ADDR_WIDTH(AddrW), .MEM_DEPTH(Depth)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (axi)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500_000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit burst_err(input logic [1:0] burst, input int unsigned len);
        return burst == 2'b11 || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Byte address of beat i, straight from the burst rules.
    function automatic int unsigned beat_addr(input int unsigned start, input int unsigned len,
                                              input logic [1:0] burst, input int unsigned i);
        int unsigned s, size, base;
        s = start & ~32'h3;
        if (burst_err(burst, len)) burst = 2'b01;
        case (burst)
            2'b00: return s;
            2'b10: begin
                size = (len + 1) * 4;
                base = s - (s % size);
                return base + ((s - base + 4 * i) % size);
            end
            default: return s + 4 * i;
        endcase
    endfunction

    task automatic model_write(input int unsigned a, input logic [31:0] d, input logic [3:0] st);
        if (a < MemBytes) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) ref_mem[a >> 2][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_awready"}, 32'(axi.awready), 0);
        check({tag, "_wready"},  32'(axi.wready),  0);
        check({tag, "_bvalid"},  32'(axi.bvalid),  0);
        check({tag, "_arready"}, 32'(axi.arready), 0);
        check({tag, "_rvalid"},  32'(axi.rvalid),  0);
        check({tag, "_rlast"},   32'(axi.rlast),   0);
        check({tag, "_bresp"},   32'(axi.bresp),   0);
        check({tag, "_rresp"},   32'(axi.rresp),   0);
        check({tag, "_bid"},     32'(axi.bid),     0);
        check({tag, "_rid"},     32'(axi.rid),     0);
        check({tag, "_rdata"},   axi.rdata,        0);
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        int n = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awvalid = 1'b1;
        while (axi.awready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        check("awready_wait", 32'(axi.awready), 1);
        @(posedge aclk); #1;
        axi.awvalid = 1'b0;
        check("awready_busy", 32'(axi.awready), 0);
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] st, input logic last);
        int n = 0;
        axi.wdata = d; axi.wstrb = st; axi.wlast = last; axi.wvalid = 1'b1;
        while (axi.wready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        check("wready_wait", 32'(axi.wready), 1);
        @(posedge aclk); #1;
        axi.wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                            input logic [1:0] burst, input int bad_beat);
        logic [1:0]  exp_resp;
        logic [1:0]  r;
        logic        last;
        int unsigned a;
        int          d;
        exp_resp = 2'b00;
        aw_phase(id, addr, 8'(len), burst);
        for (int i = 0; i <= int'(len); i++) begin
            a    = beat_addr(addr, len, burst, i);
            last = (i == int'(len)) ^ (i == bad_beat);
            if (a >= MemBytes) r = 2'b11;
            else if (burst_err(burst, len) || last != (i == int'(len))) r = 2'b10;
            else r = 2'b00;
            if (r > exp_resp) exp_resp = r;
            model_write(a, wd[i], ws[i]);
            w_beat(wd[i], ws[i], last);
        end
        check("bvalid_after_last", 32'(axi.bvalid), 1);
        check("wready_after_last", 32'(axi.wready), 0);
        d = $urandom_range(0, 3);
        repeat (d) begin
            check("bid_hold", 32'(axi.bid), 32'(id));
            check("bresp_hold", 32'(axi.bresp), 32'(exp_resp));
            @(posedge aclk); #1;
        end
        check("bid", 32'(axi.bid), 32'(id));
        check("bresp", 32'(axi.bresp), 32'(exp_resp));
        axi.bready = 1'b1;
        @(posedge aclk); #1;
        axi.bready = 1'b0;
        check("bvalid_clear", 32'(axi.bvalid), 0);
    endtask

    task automatic do_read(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                           input logic [1:0] burst, input int stall_beat, input int stall_cycles);
        int          n;
        int          stall;
        int unsigned a;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        axi.arid = id; axi.araddr = addr; axi.arlen = 8'(len); axi.arburst = burst;
        axi.arvalid = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
        check("arready_wait", 32'(axi.arready), 1);
        @(posedge aclk); #1;
        axi.arvalid = 1'b0;
        check("arready_busy", 32'(axi.arready), 0);
        for (int i = 0; i <= int'(len); i++) begin
            a     = beat_addr(addr, len, burst, i);
            exp_d = (a < MemBytes) ? ref_mem[a >> 2] : 32'h0;
            exp_r = (a >= MemBytes) ? 2'b11 : (burst_err(burst, len) ? 2'b10 : 2'b00);
            axi.rready = 1'b0;
            n = 0;
            while (axi.rvalid !== 1'b1 && n < 50) begin @(posedge aclk); #1; n++; end
            check("rvalid", 32'(axi.rvalid), 1);
            stall = (i == stall_beat) ? stall_cycles : $urandom_range(0, 1);
            repeat (stall) begin
                check("rdata_hold", axi.rdata, exp_d);
                check("rresp_hold", 32'(axi.rresp), 32'(exp_r));
                check("rlast_hold", 32'(axi.rlast), 32'(i == int'(len)));
                @(posedge aclk); #1;
            end
            check("rdata", axi.rdata, exp_d);
            check("rresp", 32'(axi.rresp), 32'(exp_r));
            check("rlast", 32'(axi.rlast), 32'(i == int'(len)));
            check("rid", 32'(axi.rid), 32'(id));
            axi.rready = 1'b1;
            @(posedge aclk); #1;
            axi.rready = 1'b0;
        end
        check("rvalid_clear", 32'(axi.rvalid), 0);
    endtask

    initial begin
        int unsigned len, addr;
        logic [1:0]  burst;
        int          bad;
        for (int i = 0; i < int'(Depth); i++) ref_mem[i] = 32'h0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awburst = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arburst = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;

        // Reset state and ready rising on the first edge after release.
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check("awready_pre_edge", 32'(axi.awready), 0);
        check("arready_pre_edge", 32'(axi.arready), 0);
        @(posedge aclk); #1;
        check("awready_post_edge", 32'(axi.awready), 1);
        check("arready_post_edge", 32'(axi.arready), 1);

        // INCR write/read of four words at 0x10.
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd1, 32'h10, 3, 2'b01, -1);
        do_read(4'd1, 32'h10, 3, 2'b01, -1, 0);

        // WRAP read from 0x18 visits 0x18, 0x1C, 0x10, 0x14.
        do_read(4'd2, 32'h18, 3, 2'b10, -1, 0);

        // Partial strobe into an untouched word.
        wd[0] = 32'h12345678; ws[0] = 4'b0101;
        do_write(4'd3, 32'h40, 0, 2'b01, -1);
        do_read(4'd3, 32'h40, 0, 2'b01, -1, 0);

        // Out-of-range write must not alias onto word 0.
        wd[0] = 32'h11111111; ws[0] = 4'hF;
        do_write(4'd4, 32'h0, 0, 2'b01, -1);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd5, MemBytes, 0, 2'b01, -1);
        do_read(4'd5, 32'h0, 0, 2'b01, -1, 0);
        do_read(4'd6, MemBytes - 8, 3, 2'b01, -1, 0);
        do_read(4'd7, 32'h10, 3, 2'b01, 1, 5);

        // Reserved burst and illegal WRAP length, plus a misplaced wlast.
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd8, 32'h80, 2, 2'b11, -1);
        do_write(4'd9, 32'hA0, 4, 2'b10, 2);
        do_read(4'd9, 32'h80, 5, 2'b10, -1, 0);

        // Asynchronous reset in the middle of beat 2 of an 8-beat write.
        aw_phase(4'd10, 32'h100, 8'd7, 2'b01);
        for (int i = 0; i < 2; i++) begin
            model_write(32'h100 + 4 * i, 32'hC0 + 32'(i), 4'hF);
            w_beat(32'hC0 + 32'(i), 4'hF, 1'b0);
        end
        axi.wdata = 32'hC2; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        check_outputs_zero("midburst_reset");
        axi.wvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        for (int i = 0; i < 2; i++) begin wd[i] = 32'hE0 + 32'(i); ws[i] = 4'hF; end
        do_write(4'd11, 32'h200, 1, 2'b01, -1);
        do_read(4'd12, 32'h100, 7, 2'b01, -1, 0);

        // Randomized write-then-read bursts.
        for (int t = 0; t < 30; t++) begin
            burst = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: len = 0;
                1: len = 1;
                2: len = 3;
                3: len = 7;
                4: len = 15;
                default: len = $urandom_range(0, 20);
            endcase
            if ($urandom_range(0, 7) == 0) addr = MemBytes - 4 * $urandom_range(0, 8);
            else addr = 4 * $urandom_range(0, Depth - 1);
            addr = addr + $urandom_range(0, 3);
            for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
            do_write(4'($urandom), addr, len, burst, bad);
            do_read(4'($urandom), addr, len, burst, int'($urandom_range(0, len)),
                    int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
